// File: rtl/led_strip_driver_if.sv
// Host-side bundle for led_strip_driver: pixel write port plus frame start/busy/done.
// Handshake: wr_en is fire-and-forget and is accepted every cycle. start is a level
// request sampled only while busy=0. busy=1 acknowledges it and holds for the whole
// frame. done pulses for one cycle as busy falls. A start seen while busy=1 is dropped.
interface led_strip_driver_if #(
  parameter int ADDR_W = 3
) ();
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_rgb;
  logic              start;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_rgb, start,
    input  busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_rgb, start,
    output busy, done
  );
endinterface

// File: rtl/led_strip_driver.sv
// WS2812-class strip driver: N_LEDS pixel RAM, whole-strip transmit on start, latch gap.
// Optional LED_STRIP_BRIGHTNESS_EN adds a global brightness scaler on the bright port.
module led_strip_driver #(
  parameter int N_LEDS = 8,
  parameter int ADDR_W = 3,
  parameter int T0H    = 20,
  parameter int T1H    = 40,
  parameter int TBIT   = 63,
  parameter int TRST   = 2600
) (
  input  logic                clk50,
  input  logic                rst,
  led_strip_driver_if.slave   bus,
`ifdef LED_STRIP_BRIGHTNESS_EN
  input  logic [7:0]          bright,
`endif
  output logic                o,
  output logic [ADDR_W-1:0]   led_idx,
  output logic [4:0]          bit_idx,
  output logic [1:0]          dbg_state
);
  localparam int CW = $clog2(TBIT);
  localparam int LW = $clog2(TRST);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

  state_t            state, state_nxt;
  logic [23:0]       mem [2**ADDR_W];
  logic [23:0]       shreg;
  logic [CW-1:0]     cyc_cnt;
  logic [LW-1:0]     lat_cnt;
  logic              done_q;
  logic              done_nxt;
  logic              load_pix;
  logic              bit_end;
  logic              pix_end;
  logic              last_pix;
  logic [ADDR_W-1:0] ld_addr;
  logic [23:0]       rd_word;
  logic [23:0]       ld_word;
  logic [CW-1:0]     th;

  assign bit_end  = (cyc_cnt == CW'(TBIT - 1));
  assign pix_end  = bit_end && (bit_idx == 5'd23);
  assign last_pix = ({1'b0, led_idx} == (ADDR_W + 1)'(N_LEDS - 1));

  // Write before read in the same edge is not visible: reads see the array before the NBA.
  always_ff @(posedge clk50) begin
    if (bus.wr_en && ({1'b0, bus.wr_addr} < (ADDR_W + 1)'(N_LEDS)))
      mem[bus.wr_addr] <= bus.wr_rgb;
  end

  assign rd_word = mem[ld_addr];

`ifdef LED_STRIP_BRIGHTNESS_EN
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction

  assign ld_word = {scale8(rd_word[15:8], bright),
                    scale8(rd_word[23:16], bright),
                    scale8(rd_word[7:0], bright)};
`else
  // Reorder to wire order G, R, B so the shifter just sends MSB first.
  assign ld_word = {rd_word[15:8], rd_word[23:16], rd_word[7:0]};
`endif

  always_ff @(posedge clk50) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_pix  = 1'b0;
    done_nxt  = 1'b0;
    ld_addr   = led_idx + ADDR_W'(1);
    case (state)
      IDLE:  if (bus.start) state_nxt = LOAD;
      LOAD: begin
        state_nxt = SEND;
        load_pix  = 1'b1;
        ld_addr   = '0;
      end
      SEND: begin
        // Prefetch of the next pixel lands on the same edge that ends bit 23.
        if (pix_end) begin
          if (last_pix) state_nxt = LATCH;
          else          load_pix  = 1'b1;
        end
      end
      LATCH: begin
        if (lat_cnt == LW'(TRST - 1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      shreg   <= '0;
      cyc_cnt <= '0;
      lat_cnt <= '0;
      led_idx <= '0;
      bit_idx <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q  <= done_nxt;
      cyc_cnt <= (state == SEND && !bit_end) ? cyc_cnt + CW'(1) : '0;
      lat_cnt <= (state == LATCH && state_nxt == LATCH) ? lat_cnt + LW'(1) : '0;
      if (load_pix)
        shreg <= ld_word;
      else if (state == SEND && bit_end)
        shreg <= {shreg[22:0], 1'b0};
      if (state == SEND && bit_end) begin
        if (pix_end) begin
          bit_idx <= '0;
          led_idx <= last_pix ? '0 : led_idx + ADDR_W'(1);
        end else begin
          bit_idx <= bit_idx + 5'd1;
        end
      end
    end
  end

  always_comb begin
    th = shreg[23] ? CW'(T1H) : CW'(T0H);
    o  = (state == SEND) && (cyc_cnt < th);
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_q;
  assign dbg_state = state;
endmodule
